// File: rtl/lsu_pkg.sv
// Shared load/store-unit definitions: bus controller state encoding and default constants.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int          DMEM_TIMEOUT_DEF = 255;
    localparam logic [3:0]  BE_NONE          = 4'b0000;

endpackage

// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: turns MEM-stage load/store requests into a req/gnt/rvalid
// bus handshake, freezes the pipeline while the access is in flight and aborts on timeout.
module dmem_bus_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = DMEM_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] be_wd,
    input  logic [3:0]  byte_enable,
    output logic [31:0] r_d,
    output logic        stall,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] r_d_q, r_d_d;
    logic        fault_c;
    logic        acc;
    logic        be_ok;
    logic        cnt_hit;

    assign acc     = mem_read | mem_write;
    assign be_ok   = (byte_enable != BE_NONE);
    assign cnt_hit = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            r_d_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            r_d_q   <= r_d_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        r_d_d   = r_d_q;
        fault_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (acc && be_ok) begin
                    // A simultaneous read+write request is issued as a store.
                    addr_d  = {addr[31:2], 2'b00};
                    wdata_d = be_wd;
                    be_d    = byte_enable;
                    we_d    = mem_write;
                    cnt_d   = 8'd0;
                    state_d = ST_REQ;
                end else if (acc) begin
                    fault_c = 1'b1;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + 8'd1;
                // Completion is checked before the timeout so it always wins a tie.
                if (bus_gnt && we_q) begin
                    state_d = ST_DONE;
                end else if (bus_gnt && bus_rvalid) begin
                    r_d_d   = bus_rdata;
                    state_d = ST_DONE;
                end else if (cnt_hit) begin
                    fault_c = 1'b1;
                    r_d_d   = 32'd0;
                    state_d = ST_DONE;
                end else if (bus_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (bus_rvalid) begin
                    r_d_d   = bus_rdata;
                    state_d = ST_DONE;
                end else if (cnt_hit) begin
                    fault_c = 1'b1;
                    r_d_d   = 32'd0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus_req   = (state_q == ST_REQ);
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_be    = be_q;
    assign r_d       = r_d_q;
    assign stall     = acc & be_ok & (state_q != ST_DONE);
    assign fault     = rst_n & fault_c;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Directed bench for dmem_bus_ctrl: load, delayed-grant store, misaligned access,
// timeout abort, same-cycle gnt/rvalid and asynchronous reset mid-access.
module tb_dmem_bus_ctrl;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] be_wd;
    logic [3:0]  byte_enable;
    logic [31:0] r_d;
    logic        stall;
    logic        fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int stall_cnt;
    int req_cnt;
    int fault_cnt;

    dmem_bus_ctrl #(.TIMEOUT(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .addr        (addr),
        .be_wd       (be_wd),
        .byte_enable (byte_enable),
        .r_d         (r_d),
        .stall       (stall),
        .fault       (fault),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_be      (bus_be),
        .bus_gnt     (bus_gnt),
        .bus_rvalid  (bus_rvalid),
        .bus_rdata   (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Sample point in the middle of the current cycle.
    task automatic to_neg();
        @(negedge clk);
    endtask

    // Advance past the next rising edge to drive the following cycle's inputs.
    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        addr        = 32'd0;
        be_wd       = 32'd0;
        byte_enable = 4'd0;
        bus_gnt     = 1'b0;
        bus_rvalid  = 1'b0;
        bus_rdata   = 32'd0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #12;
        check_eq("rst_bus_req", 32'(bus_req), 32'd0);
        check_eq("rst_bus_addr", bus_addr, 32'd0);
        check_eq("rst_bus_be", 32'(bus_be), 32'd0);
        check_eq("rst_r_d", r_d, 32'd0);
        check_eq("rst_fault", 32'(fault), 32'd0);
        check_eq("rst_stall", 32'(stall), 32'd0);
        to_next();
        rst_n = 1'b1;
        to_next();

        // Load, gnt in first REQ cycle, rvalid one cycle later.
        mem_read = 1'b1; addr = 32'h0000_1006; byte_enable = 4'b0100;
        stall_cnt = 0;
        to_neg();
        stall_cnt += int'(stall);
        check_eq("ld_idle_req", 32'(bus_req), 32'd0);
        to_next();
        bus_gnt = 1'b1;
        to_neg();
        stall_cnt += int'(stall);
        check_eq("ld_req", 32'(bus_req), 32'd1);
        check_eq("ld_bus_addr", bus_addr, 32'h0000_1004);
        check_eq("ld_bus_be", 32'(bus_be), 32'h4);
        check_eq("ld_bus_we", 32'(bus_we), 32'd0);
        to_next();
        bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hA1B2_C3D4;
        to_neg();
        stall_cnt += int'(stall);
        check_eq("ld_wait_req", 32'(bus_req), 32'd0);
        to_next();
        bus_rvalid = 1'b0; bus_rdata = 32'd0;
        to_neg();
        check_eq("ld_done_stall", 32'(stall), 32'd0);
        check_eq("ld_done_r_d", r_d, 32'hA1B2_C3D4);
        check_eq("ld_stall_cycles", 32'(stall_cnt), 32'd3);
        to_next();
        idle_inputs();
        to_next();

        // Store with grant held off for 4 cycles; address input wanders meanwhile.
        mem_write = 1'b1; addr = 32'h0000_2002; be_wd = 32'h00EF_0000; byte_enable = 4'b0100;
        req_cnt = 0; fault_cnt = 0;
        to_neg();
        fault_cnt += int'(fault);
        to_next();
        addr = 32'hFFFF_FFFF; be_wd = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            bus_gnt = (i == 4);
            to_neg();
            req_cnt   += int'(bus_req);
            fault_cnt += int'(fault);
            check_eq($sformatf("st_addr_%0d", i), bus_addr, 32'h0000_2000);
            check_eq($sformatf("st_wdata_%0d", i), bus_wdata, 32'h00EF_0000);
            check_eq($sformatf("st_we_%0d", i), 32'(bus_we), 32'd1);
            check_eq($sformatf("st_be_%0d", i), 32'(bus_be), 32'h4);
            to_next();
        end
        bus_gnt = 1'b0;
        to_neg();
        fault_cnt += int'(fault);
        check_eq("st_req_cycles", 32'(req_cnt), 32'd5);
        check_eq("st_done_req", 32'(bus_req), 32'd0);
        check_eq("st_done_stall", 32'(stall), 32'd0);
        check_eq("st_fault_cnt", 32'(fault_cnt), 32'd0);
        check_eq("st_r_d_kept", r_d, 32'hA1B2_C3D4);
        to_next();
        idle_inputs();
        to_next();

        // Misaligned load: byte_enable of zero.
        mem_read = 1'b1; addr = 32'h0000_0003; byte_enable = 4'b0000;
        to_neg();
        check_eq("mis_fault", 32'(fault), 32'd1);
        check_eq("mis_stall", 32'(stall), 32'd0);
        check_eq("mis_req", 32'(bus_req), 32'd0);
        to_next();
        idle_inputs();
        to_neg();
        check_eq("mis_fault_clr", 32'(fault), 32'd0);
        check_eq("mis_req_after", 32'(bus_req), 32'd0);
        to_next();

        // Timeout: grant never arrives, TIMEOUT=8.
        mem_read = 1'b1; addr = 32'h0000_3000; byte_enable = 4'b1111;
        to_next();
        fault_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            to_neg();
            fault_cnt += int'(fault);
            to_next();
        end
        check_eq("to_no_early_fault", 32'(fault_cnt), 32'd0);
        to_neg();
        check_eq("to_fault", 32'(fault), 32'd1);
        check_eq("to_req_last", 32'(bus_req), 32'd1);
        to_next();
        bus_rvalid = 1'b1; bus_rdata = 32'h5555_5555;
        to_neg();
        check_eq("to_done_req", 32'(bus_req), 32'd0);
        check_eq("to_done_fault", 32'(fault), 32'd0);
        check_eq("to_done_r_d", r_d, 32'd0);
        to_next();
        idle_inputs();
        bus_rvalid = 1'b1; bus_rdata = 32'h6666_6666;
        to_next();
        bus_rvalid = 1'b0;
        to_neg();
        check_eq("to_rvalid_ignored", r_d, 32'd0);
        to_next();

        // gnt and rvalid in the same REQ cycle skip WAIT.
        mem_read = 1'b1; addr = 32'h0000_4008; byte_enable = 4'b1111;
        to_next();
        bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
        to_neg();
        check_eq("same_req", 32'(bus_req), 32'd1);
        to_next();
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
        to_neg();
        check_eq("same_done_stall", 32'(stall), 32'd0);
        check_eq("same_r_d", r_d, 32'h1234_5678);
        to_next();
        idle_inputs();
        to_next();

        // Second load, reset pulsed while waiting for read data.
        mem_read = 1'b1; addr = 32'h0000_5000; byte_enable = 4'b1111;
        to_next();
        bus_gnt = 1'b1;
        to_next();
        bus_gnt = 1'b0;
        to_neg();
        check_eq("rw_wait_stall", 32'(stall), 32'd1);
        to_next();
        rst_n = 1'b0;
        #1;
        check_eq("rw_rst_req", 32'(bus_req), 32'd0);
        check_eq("rw_rst_fault", 32'(fault), 32'd0);
        check_eq("rw_rst_addr", bus_addr, 32'd0);
        check_eq("rw_rst_r_d", r_d, 32'd0);
        to_next();
        idle_inputs();
        rst_n = 1'b1;
        bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        to_next();
        bus_rvalid = 1'b0; bus_rdata = 32'd0;
        to_neg();
        check_eq("rw_late_rvalid", r_d, 32'd0);
        check_eq("rw_late_req", 32'(bus_req), 32'd0);
        check_eq("rw_late_fault", 32'(fault), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_bus_ctrl.md
DMEM_BUS_CTRL -- requirements
Module: dmem_bus_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 255, maximum cycles spent in REQ+WAIT before the access is aborted (range 2..255).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: mem_read  input  1  MEM-stage load request.
REQ-005 Port: mem_write  input  1  MEM-stage store request.
REQ-006 Port: addr  input  32  byte address from the ALU.
REQ-007 Port: be_wd  input  32  lane-aligned store data from the byte-enable stage.
REQ-008 Port: byte_enable  input  4  lane mask from the byte-enable stage; 4'b0000 marks a misaligned or illegal access.
REQ-009 Port: r_d  output  32  raw read word returned to the byte-enable stage.
REQ-010 Port: stall  output  1  pipeline freeze request.
REQ-011 Port: fault  output  1  one-cycle pulse on a misaligned access or a timeout.
REQ-012 Port: bus_req, bus_we  output  1 each  bus request and write strobe.
REQ-013 Port: bus_addr, bus_wdata  output  32 each  word address ([1:0]=2'b00) and write data.
REQ-014 Port: bus_be  output  4  bus lane mask.
REQ-015 Port: bus_gnt, bus_rvalid  input  1 each  request accepted; read data valid.
REQ-016 Port: bus_rdata  input  32  read data.

Function
REQ-017 FSM states: IDLE, REQ, WAIT, DONE.
REQ-018 Access condition: acc = (mem_read|mem_write).
REQ-019 If mem_read and mem_write are both high, the block treats the access as a write.
REQ-020 IDLE, acc, byte_enable!=0: capture {addr[31:2],2'b00}, be_wd, byte_enable and we=mem_write into bus registers; next state REQ.
REQ-021 IDLE, acc, byte_enable==0: fault=1 for exactly that cycle, no bus access, stall=0, state stays IDLE.
REQ-022 REQ: bus_req=1 and bus outputs stable until bus_gnt.
REQ-023 REQ with bus_gnt on a write: next state DONE.
REQ-024 REQ with bus_gnt on a read: next state WAIT; if bus_rvalid is also high that cycle, capture bus_rdata into r_d and go to DONE.
REQ-025 WAIT: on bus_rvalid, r_d<=bus_rdata; next state DONE.
REQ-026 bus_rvalid is ignored in IDLE and DONE, and in REQ unless bus_gnt is also high.
REQ-027 DONE: bus_req=0, stall=0 for one cycle; next state IDLE.
REQ-028 stall = acc & (byte_enable!=0) & (state!=DONE), combinational.
REQ-029 Read latency with gnt on the first REQ cycle and rvalid one cycle later: stall is high for 3 cycles, then low in DONE.
REQ-030 r_d holds its last captured value; stores do not modify it.
REQ-031 An 8-bit counter clears on entering REQ and increments each cycle in REQ or WAIT.
REQ-032 When the counter reaches TIMEOUT-1 without completion: fault pulses for 1 cycle, r_d<=0, bus_req drops, next state DONE.
REQ-033 Completion and timeout in the same cycle: completion wins and fault stays 0.
REQ-034 bus_addr, bus_wdata, bus_be and bus_we are registered and change only on entry to REQ.

Reset
REQ-035 rst_n low asynchronously forces: state=IDLE, counter=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0, r_d=0, fault=0.
REQ-036 Reset asserted mid-access abandons the access with no fault pulse.
REQ-037 A late bus_rvalid arriving after reset, while in IDLE, is ignored.

Structure
REQ-038 Shared package lsu_pkg holds the state enum type, DMEM_TIMEOUT_DEF=255 and BE_NONE=4'b0000.
REQ-039 The timeout counter and FSM are implemented inline, with no sub-module.

Verification
REQ-040 Bench scenario: load addr=0x1006, byte_enable=4'b0100, gnt on cycle 1, rvalid on cycle 2 with rdata=0xA1B2C3D4 -> bus_addr=0x1004, bus_be=4'b0100, stall high 3 cycles, r_d=0xA1B2C3D4 in DONE.
REQ-041 Bench scenario: store be_wd=0x00EF0000, byte_enable=4'b0100, gnt delayed 4 cycles -> bus_req high 5 cycles with stable outputs, bus_we=1, DONE follows, fault=0.
REQ-042 Bench scenario: load with byte_enable=0 -> fault=1 for one cycle, bus_req never high, stall=0.
REQ-043 Bench scenario: TIMEOUT=8, gnt never asserted -> fault pulse after 8 cycles in REQ, r_d=0, bus_req low in DONE.
REQ-044 Bench scenario: gnt and rvalid in the same REQ cycle -> WAIT is skipped and r_d is captured; then rst_n pulsed low during WAIT of a second load -> bus_req=0 immediately, and a following rvalid leaves r_d unchanged.
